// File: rtl/cdb_scheduler.sv
// Common-data-bus reservation scheduler: books future CDB write-back slots for
// fixed-latency functional units and round-robin arbitrates their issue requests.
module cdb_scheduler #(
    parameter int unsigned               NUM_FU = 4,
    parameter int unsigned               LAT_W  = 3,
    parameter int unsigned               DEPTH  = 8,
    parameter logic [NUM_FU*LAT_W-1:0]   FU_LAT = {3'd6, 3'd3, 3'd0, 3'd0},
    parameter int unsigned               ID_W   = $clog2(NUM_FU)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_FU-1:0]            issue_req,
    input  logic                         flush,
    output logic [NUM_FU-1:0]            issue_grant,
    output logic                         cdb_valid,
    output logic [ID_W-1:0]              cdb_fu_id,
    output logic [DEPTH-1:0]             cdb_status,
    output logic [$clog2(DEPTH+1)-1:0]   occ_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            slot_q,  slot_d;
    logic [DEPTH-1:0][ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]             rr_q,    rr_d;

    logic [NUM_FU-1:0]           eligible;
    logic                        grant_any;
    int unsigned                 grant_idx;
    int unsigned                 grant_lat;

    always_comb begin : arbitrate
        logic [DEPTH-1:0] ahead;
        ahead    = '0;
        eligible = '0;
        // Slot L+1 shifts into L on this edge; shifting past the top means free.
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            ahead       = slot_q >> (32'(FU_LAT[i*LAT_W +: LAT_W]) + 32'd1);
            eligible[i] = issue_req[i] && !ahead[0] && !flush;
        end

        grant_any = 1'b0;
        grant_idx = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (!grant_any && eligible[i] && (i == (32'(rr_q) + k) % NUM_FU)) begin
                    grant_any = 1'b1;
                    grant_idx = i;
                end
            end
        end

        issue_grant = '0;
        grant_lat   = 0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (grant_any && (i == grant_idx)) begin
                issue_grant[i] = 1'b1;
                grant_lat      = 32'(FU_LAT[i*LAT_W +: LAT_W]);
            end
        end
    end

    always_comb begin : next_state
        slot_d  = slot_q >> 1;
        owner_d = owner_q >> ID_W;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (grant_any && (k == grant_lat)) begin
                slot_d[k]  = 1'b1;
                owner_d[k] = ID_W'(grant_idx);
            end
        end

        rr_d = rr_q;
        if (grant_any) begin
            rr_d = ID_W'((grant_idx + 1) % NUM_FU);
        end

        if (flush) begin
            slot_d  = '0;
            owner_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            slot_q  <= slot_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin : outputs
        cdb_valid  = slot_q[0];
        cdb_fu_id  = slot_q[0] ? owner_q[0] : '0;
        cdb_status = slot_q;
        occ_count  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ_count = occ_count + CNT_W'(slot_q[k]);
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Scoreboard bench for cdb_scheduler: directed issue vectors push expected CDB
// ownership events; a negedge monitor matches them against the bus.
module tb_cdb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  issue_req;
    logic        flush;
    logic [3:0]  issue_grant;
    logic        cdb_valid;
    logic [1:0]  cdb_fu_id;
    logic [7:0]  cdb_status;
    logic [3:0]  occ_count;

    cdb_scheduler #(
        .NUM_FU (4),
        .LAT_W  (3),
        .DEPTH  (8),
        .FU_LAT ({3'd6, 3'd3, 3'd0, 3'd0})
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_req   (issue_req),
        .flush       (flush),
        .issue_grant (issue_grant),
        .cdb_valid   (cdb_valid),
        .cdb_fu_id   (cdb_fu_id),
        .cdb_status  (cdb_status),
        .occ_count   (occ_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cyc;
        int id;
    } exp_t;
    exp_t sb[$];

    int lat_tab[4] = '{0, 0, 3, 6};

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    int mon_hit;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_hit = -1;
            foreach (sb[i]) if (sb[i].cyc == cyc) mon_hit = i;
            if (mon_hit >= 0) begin
                chk("cdb_valid", 32'(cdb_valid), 32'd1);
                chk("cdb_fu_id", 32'(cdb_fu_id), 32'(sb[mon_hit].id));
                sb.delete(mon_hit);
            end else begin
                chk("cdb_idle_valid", 32'(cdb_valid), 32'd0);
                chk("cdb_idle_id", 32'(cdb_fu_id), 32'd0);
            end
        end
    end

    task automatic step(input logic [3:0] req, input logic fl, input logic [3:0] exp_g,
                        input logic do_st, input logic [7:0] exp_st, input int exp_occ,
                        input string nm);
        exp_t e;
        issue_req = req;
        flush     = fl;
        @(negedge clk);
        chk({nm, "/grant"}, 32'(issue_grant), 32'(exp_g));
        if (do_st) begin
            chk({nm, "/status"}, 32'(cdb_status), 32'(exp_st));
            chk({nm, "/occ"}, 32'(occ_count), exp_occ);
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_g[i]) begin
                e.cyc = cyc + 1 + lat_tab[i];
                e.id  = i;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        issue_req = '0;
        flush     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 0, "idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        issue_req = 4'b0011;
        flush     = 1'b0;
        #7;
        chk("rst_status", 32'(cdb_status), 32'h00);
        chk("rst_occ", 32'(occ_count), 32'd0);
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_id", 32'(cdb_fu_id), 32'd0);
        chk("rst_grant", 32'(issue_grant), 32'h1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        issue_req = '0;

        // single div
        step(4'b1000, 1'b0, 4'b1000, 1'b1, 8'h00, 0, "div_issue");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h40, 1, "div_t1");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h20, 1, "div_t2");
        idle(4);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h01, 1, "div_t7");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h00, 0, "div_t8");

        // div vs mult slot conflict
        step(4'b1000, 1'b0, 4'b1000, 1'b0, 8'h00, 0, "cf_div");
        idle(2);
        step(4'b0100, 1'b0, 4'b0000, 1'b1, 8'h10, 1, "cf_blocked");
        step(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h08, 1, "cf_mult");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h0c, 2, "cf_both");
        idle(3);
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h00, 0, "cf_drain");

        // asynchronous reset mid-operation, rr_ptr left at 2
        step(4'b1000, 1'b0, 4'b1000, 1'b0, 8'h00, 0, "rs_div");
        step(4'b0100, 1'b0, 4'b0100, 1'b0, 8'h00, 0, "rs_mult");
        step(4'b0010, 1'b0, 4'b0010, 1'b0, 8'h00, 0, "rs_ldst");
        chk("rs_pre_status", 32'(cdb_status), 32'h15);
        chk("rs_pre_occ", 32'(occ_count), 32'd3);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rs_status", 32'(cdb_status), 32'h00);
        chk("rs_occ", 32'(occ_count), 32'd0);
        chk("rs_valid", 32'(cdb_valid), 32'd0);
        chk("rs_id", 32'(cdb_fu_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0101, 1'b0, 4'b0001, 1'b1, 8'h00, 0, "rs_rr0");

        // round-robin between two latency-0 units
        step(4'b0011, 1'b0, 4'b0010, 1'b1, 8'h01, 1, "rr1");
        step(4'b0011, 1'b0, 4'b0001, 1'b1, 8'h01, 1, "rr2");
        step(4'b0011, 1'b0, 4'b0010, 1'b1, 8'h01, 1, "rr3");
        step(4'b0011, 1'b0, 4'b0001, 1'b1, 8'h01, 1, "rr4");
        step(4'b0011, 1'b0, 4'b0010, 1'b1, 8'h01, 1, "rr5");
        step(4'b0011, 1'b0, 4'b0001, 1'b1, 8'h01, 1, "rr6");

        // flush with div and mult pending
        step(4'b1000, 1'b0, 4'b1000, 1'b1, 8'h01, 1, "fl_div");
        step(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h40, 1, "fl_mult");
        step(4'b0001, 1'b1, 4'b0000, 1'b1, 8'h28, 2, "fl_flush");

        // occupancy; first grant also shows rr_ptr survived the flush
        step(4'b1001, 1'b0, 4'b1000, 1'b1, 8'h00, 0, "oc_div");
        step(4'b0100, 1'b0, 4'b0100, 1'b1, 8'h40, 1, "oc_mult");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h28, 2, "oc_t2");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h14, 2, "oc_t3");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h0a, 2, "oc_t4");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h05, 2, "oc_t5");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h02, 1, "oc_t6");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h01, 1, "oc_t7");
        step(4'b0000, 1'b0, 4'b0000, 1'b1, 8'h00, 0, "oc_t8");
        idle(2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
